// File: rtl/nios2_sopc_knn_ctrl.sv
// Avalon-MM slave that sequences the KNN classifier core: one-cycle launch pulse,
// done/timeout supervision, class capture and a level interrupt.
module nios2_sopc_knn_ctrl #(
    parameter int                 DATA_W    = 16,
    parameter int                 TMO_W     = 24,
    parameter logic [TMO_W-1:0]   TMO_RESET = 24'h00FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              knn_start,
    output logic [DATA_W-1:0] knn_feature,
    input  logic              knn_done,
    input  logic [DATA_W-1:0] knn_class
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_FEATURE = 3'd2;
    localparam logic [2:0] A_CLASS   = 3'd3;
    localparam logic [2:0] A_TIMEOUT = 3'd4;
    localparam logic [2:0] A_CYCLES  = 3'd5;

    state_t             state;
    logic               irq_en;
    logic               done_flag;
    logic               tmo_flag;
    logic [DATA_W-1:0]  feature_reg;
    logic [DATA_W-1:0]  class_reg;
    logic [TMO_W-1:0]   timeout_reg;
    logic [TMO_W-1:0]   cycles_reg;
    logic [31:0]        rdata_mux;

    logic               wr_en;
    logic               ctrl_wr;
    logic               start_req;
    logic               clr_req;
    logic               busy;
    logic [TMO_W:0]     cycles_inc;
    logic [TMO_W-1:0]   cycles_sat;
    logic               tmo_hit;
    logic               unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == A_CTRL);
    assign start_req = ctrl_wr & writedata[0];
    assign clr_req   = ctrl_wr & writedata[2];
    assign busy      = (state != ST_IDLE);

    // One extra bit keeps CYCLES+1 from wrapping to 0 once the counter saturates.
    assign cycles_inc = {1'b0, cycles_reg} + (TMO_W+1)'(1);
    assign cycles_sat = (&cycles_reg) ? cycles_reg : cycles_inc[TMO_W-1:0];
    assign tmo_hit    = (timeout_reg != '0) && (cycles_inc == {1'b0, timeout_reg});

    assign irq          = done_flag & irq_en;
    assign unused_wdata = ^writedata;

    // NOTE: every variable gets a default first, so the mux cannot infer a latch.
    always_comb begin
        rdata_mux = '0;
        case (address)
            A_CTRL:    rdata_mux = {30'd0, irq_en, 1'b0};
            A_STATUS:  rdata_mux = {29'd0, tmo_flag, done_flag, busy};
            A_FEATURE: rdata_mux = 32'(feature_reg);
            A_CLASS:   rdata_mux = 32'(class_reg);
            A_TIMEOUT: rdata_mux = 32'(timeout_reg);
            A_CYCLES:  rdata_mux = 32'(cycles_reg);
            default:   rdata_mux = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; later assignments
    // in this block intentionally override earlier ones (FSM events beat CLR).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            readdata    <= '0;
            knn_start   <= 1'b0;
            knn_feature <= '0;
            irq_en      <= 1'b0;
            done_flag   <= 1'b0;
            tmo_flag    <= 1'b0;
            feature_reg <= '0;
            class_reg   <= '0;
            timeout_reg <= TMO_RESET;
            cycles_reg  <= '0;
        end else begin
            readdata  <= rdata_mux;
            knn_start <= 1'b0;

            if (ctrl_wr)
                irq_en <= writedata[1];
            if (wr_en && address == A_FEATURE)
                feature_reg <= writedata[DATA_W-1:0];
            if (wr_en && address == A_TIMEOUT)
                timeout_reg <= writedata[TMO_W-1:0];
            if (clr_req) begin
                done_flag <= 1'b0;
                tmo_flag  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        knn_feature <= feature_reg;
                        cycles_reg  <= '0;
                        done_flag   <= 1'b0;
                        tmo_flag    <= 1'b0;
                        knn_start   <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (knn_done) begin
                        class_reg <= knn_class;
                        done_flag <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cycles_reg <= cycles_sat;
                        if (tmo_hit) begin
                            tmo_flag <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
